// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master side issues operands and start; the slave side returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-adder cell on a, ~b and a carry seeded with ~bin.
// The borrow out is the inverse of the final carry.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             c_reg;
  logic             bout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] r_shift;
  logic             accept;
  logic             last_bit;

  // Full-adder slice, result shift value and handshake decode.
  always_comb begin
    sum_bit   = a_reg[0] ^ b_reg[0] ^ c_reg;
    carry_out = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
    r_shift   = r_reg >> 1;
    r_shift[WIDTH-1] = sum_bit;
    accept    = bus.start && (state_reg != RUN);
    last_bit  = (state_reg == RUN) && (cnt_reg == LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DONE can chain directly into a new operation.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-bit shifting, and result publication on the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      c_reg    <= 1'b0;
      cnt_reg  <= '0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.a;
      b_reg   <= ~bus.b;
      c_reg   <= ~bus.bin;
      cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      c_reg   <= carry_out;
      r_reg   <= r_shift;
      cnt_reg <= cnt_reg + CW'(1);
      // diff only moves once the whole word is assembled.
      if (last_bit) begin
        diff_reg <= r_shift;
        bout_reg <= ~carry_out;
      end
    end
  end

  // Status flags are pure decodes of the state register.
  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4): directed scenarios,
// an exhaustive sweep and random operations against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference result: {bout, diff} = (a - b - bin) mod 2^(W+1).
  function automatic int ref_result(input int a, input int b, input int bin);
    return (a - b - bin) & ((1 << (W + 1)) - 1);
  endfunction

  // One isolated operation with latency, busy, result and hold checks.
  task automatic run_op(input int a, input int b, input int bin, input string tag);
    int k;
    int busy_cycles;
    int exp;
    int held;
    exp = ref_result(a, b, bin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = 1'(bin);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    k = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      k++;
      if (bus.busy) busy_cycles++;
    end while (!bus.done && k < 20);
    check({tag, " latency"}, k, W + 1);
    check({tag, " busy_cycles"}, busy_cycles, W);
    check({tag, " busy_in_done"}, int'(bus.busy), 0);
    check({tag, " result"}, int'({bus.bout, bus.diff}), exp);
    held = int'({bus.bout, bus.diff});
    @(negedge clk);
    check({tag, " done_drop"}, int'(bus.done), 0);
    check({tag, " hold"}, int'({bus.bout, bus.diff}), exp);
    $display("op %s a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d", tag, a, b, bin,
             held & ((1 << W) - 1), held >> W);
  endtask

  // Global guard so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int prev;
    int bad;
    n_checks = 0;
    n_fail   = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle", int'({bus.busy, bus.done, bus.bout, bus.diff}), 0);
    end
    $display("reset idle checked");

    run_op(9, 3, 0, "9-3");
    run_op(3, 9, 0, "3-9");
    run_op(0, 0, 1, "0-0-1");
    run_op(5, 5, 0, "5-5");

    // Start raised again during RUN with other operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd4; bus.bin = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin bus.a = 4'd1; bus.b = 4'd2; end
      if (n == 3) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        check("run_start result", int'({bus.bout, bus.diff}), ref_result(12, 4, 0));
        check("run_start latency", n, W + 1);
      end
    end
    check("run_start done_count", ndone, 1);
    $display("op run-time start ignored, done pulses=%0d", ndone);

    // Start held high: one result every W+1 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd1; bus.bin = 1'b1;
    ndone = 0; prev = 0; bad = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (bus.busy == bus.done) bad++;
      if (bus.done) begin
        ndone++;
        check("b2b result", int'({bus.bout, bus.diff}), ref_result(15, 1, 1));
        if (prev > 0) check("b2b interval", n - prev, W + 1);
        prev = n;
      end
    end
    check("b2b done_count", ndone, 3);
    check("b2b busy_vs_done", bad, 0);
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);
    $display("op back-to-back 15-1-1 done pulses=%0d", ndone);

    // Reset two cycles into an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd2; bus.bin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort outputs", int'({bus.busy, bus.done, bus.bout, bus.diff}), 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    reset = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort no_done", ndone, 0);
    $display("op reset mid-run abort");
    run_op(7, 2, 0, "7-2 after reset");

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run_op(a, b, bi, "sweep");

    // Random operations.
    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
             int'($urandom_range(1, 0)), "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
